fifo_umbral: RTL and testbench

//  Synchronous single-clock FIFO with programmable almost-full/almost-empty thresholds.
//  One instance per port on each side of the transaction-layer arbiter. Input side: `fifo_empty` feeds the arbiter's FIFO_empty, and arbiter Pops drives `pop`.

---
 rtl/fifo_umbral_pkg.sv | 16 +
 rtl/fifo_umbral_memoria_fifo.sv | 31 +++
 rtl/fifo_umbral.sv | 101 ++++++++++
 tb/tb_fifo_umbral.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbral_pkg.sv
// Shared defaults and field positions for the fifo_umbral slice.
// Word layout: the destination field sits in the top two data bits.
package fifo_umbral_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 6;
  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEST_MSB       = DEF_DATA_WIDTH - 1;
  localparam int unsigned DEST_LSB       = DEF_DATA_WIDTH - 2;

  typedef logic [DEST_MSB-DEST_LSB:0] dest_t;

  function automatic dest_t dest_of(input logic [DEF_DATA_WIDTH-1:0] word);
    return word[DEST_MSB -: 2];
  endfunction

endpackage

// File: rtl/fifo_umbral_memoria_fifo.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// synchronous read port whose output register updates only on a read.
module memoria_fifo
  import fifo_umbral_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Read-before-write on an address collision returns the old word.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable almost-full / almost-empty thresholds.
// Define FIFO_ERR_EN to add the sticky `error` output for dropped push/pop.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERR_EN
  output logic                  error,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_valid;
  logic                  r_rd_seen;
  logic                  w_push_ok, w_pop_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign fifo_empty   = (r_count == '0);
  assign fifo_full    = (r_count == DEPTH_CNT);
  assign almost_full  = ((DEPTH_CNT - r_count) <= {1'b0, umbral_alto});
  assign almost_empty = (r_count <= {1'b0, umbral_bajo});

  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign w_push_ok = push & (~fifo_full | pop);
  assign w_pop_ok  = pop & ~fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_rd_seen <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_seen <= 1'b1;
      end
      r_valid <= w_pop_ok;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  logic r_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if ((push & ~w_push_ok) | (pop & ~w_pop_ok)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`endif

  memoria_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .i_wr_en  (w_push_ok),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(data_in),
    .i_rd_en  (w_pop_ok),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_rd_data)
  );

  // The memory read register has no reset; mask it until a pop since reset.
  assign data_out  = r_rd_seen ? w_rd_data : '0;
  assign valid_out = r_valid;
  assign count     = r_count;

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral: queue-based reference model, directed
// scenarios followed by randomized push/pop/threshold traffic.
module tb_fifo_umbral;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] umbral_alto = 3'd1;
  logic [AW-1:0] umbral_bajo = 3'd2;
  logic [DW-1:0] data_out;
  logic          valid_out, fifo_empty, fifo_full, almost_full, almost_empty;
  logic [AW:0]   count;
`ifdef FIFO_ERR_EN
  logic          error;
`endif

  fifo_umbral dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .umbral_alto (umbral_alto),
    .umbral_bajo (umbral_bajo),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
`ifdef FIFO_ERR_EN
    .error       (error),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] mq[$];
  exp_t          expq[$];
  bit            m_err = 1'b0;
  logic [DW-1:0] last_out = '0;
  bit            rnd_thr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("fifo_empty", 32'(fifo_empty), 32'(sz == 0));
    chk("fifo_full", 32'(fifo_full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'((DEPTH - sz) <= int'(umbral_alto)));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= int'(umbral_bajo)));
`ifdef FIFO_ERR_EN
    chk("error", 32'(error), 32'(m_err));
`endif
  endtask

  // Called at a negedge: check what the last edge produced, then drive the next cycle.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
    int sz;
    bit pa, qa;
    check_state();
    sz = mq.size();
    qa = q && (sz > 0);
    pa = p && ((sz < DEPTH) || qa);
    if ((p && !pa) || (q && !qa)) m_err = 1'b1;
    if (qa) expq.push_back('{d: mq.pop_front(), due: cyc + 1});
    if (pa) mq.push_back(d);
    if (rnd_thr) begin
      umbral_alto = AW'($urandom_range(7, 0));
      umbral_bajo = AW'($urandom_range(7, 0));
    end
    push = p;
    pop = q;
    data_in = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, base + DW'(i), 1'b0);
  endtask

  task automatic reset_mid();
    #2 reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
`ifdef FIFO_ERR_EN
    chk("rst_error", 32'(error), 32'd0);
`endif
    mq.delete();
    expq.delete();
    m_err = 1'b0;
    last_out = '0;
    push = 1'b0;
    pop = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (reset) begin
      if (valid_out) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL spurious_valid at cycle %0d: got data %0h, expected no word", cyc,
                   data_out);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (data_out !== e.d || e.due != cyc) begin
            n_err++;
            $display("FAIL pop_data at cycle %0d: got %0h, expected %0h due cycle %0d", cyc,
                     data_out, e.d, e.due);
          end
          last_out = e.d;
        end
      end else begin
        n_vec++;
        if (expq.size() > 0 && expq[0].due <= cyc) begin
          n_err++;
          $display("FAIL missing_valid at cycle %0d: got valid 0, expected word %0h", cyc,
                   expq[0].d);
          void'(expq.pop_front());
        end else if (data_out !== last_out) begin
          n_err++;
          $display("FAIL data_hold at cycle %0d: got %0h, expected %0h", cyc, data_out,
                   last_out);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(fifo_empty), 32'd1);
    chk("reset_almost_empty", 32'(almost_empty), 32'd1);
    chk("reset_full", 32'(fifo_full), 32'd0);
    chk("reset_almost_full", 32'(almost_full), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Fill then drain with almost_full threshold of one free slot.
    fill(6'h01);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    idle(2);

    // Pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(6'h10 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, DW'(6'h20 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    idle(2);

    // Simultaneous push/pop while full, then drain.
    fill(6'h30);
    step(1'b1, 6'h2A, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    idle(2);

    // Simultaneous push/pop while empty.
    step(1'b1, 6'h15, 1'b1);
    step(1'b0, '0, 1'b1);
    idle(2);

    // Push while full, then asynchronous reset mid-burst.
    fill(6'h08);
    step(1'b1, 6'h3F, 1'b0);
    step(1'b1, 6'h3E, 1'b0);
    reset_mid();
    step(1'b0, '0, 1'b1);
    idle(2);

    // Random traffic with thresholds moving every cycle.
    rnd_thr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99, 0) < 55), DW'($urandom), ($urandom_range(99, 0) < 45));
    end
    rnd_thr = 1'b0;
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
